vga_pattern_sched: RTL
======================

VGA_PATTERN_SCHED -- requirements
Module: vga_pattern_sched

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 4: number of selectable patterns, range 2..16.
REQ-002 SHALL have parameter SEL_W, default 2: pattern_sel width, with 2^SEL_W >= NUM_PATTERNS.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536: stable-cycle count for button acceptance, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse from the VGA timing generator at start of vertical blanking.
REQ-007 SHALL have port btn_next, input, 1 bit: raw asynchronous "next pattern" button, active-high.
REQ-008 SHALL have port auto_en, input, 1 bit: level, enables automatic pattern cycling.
REQ-009 SHALL have port hold_frames, input, 6 bits: frames per pattern in auto mode.
REQ-010 SHALL have port sel_load, input, 1 bit: one-cycle pulse requesting a direct pattern load.
REQ-011 SHALL have port sel_value, input, SEL_W bits: pattern to load, sampled when sel_load=1.
REQ-012 SHALL have port pattern_sel, output, SEL_W bits: registered pattern index to the pattern datapath.
REQ-013 SHALL have port pattern_changed, output, 1 bit: one-cycle pulse coincident with each new pattern_sel value.
REQ-014 SHALL have port pending, output, 1 bit: a switch request is waiting for frame_start.
REQ-015 SHALL have port frame_cnt, output, 6 bits: frames elapsed on current pattern in auto mode.

Function
REQ-016 SHALL pass btn_next through a 2-flop synchronizer before any other use.
REQ-017 SHALL generate a next-request on the rising edge of the conditioned button; one request per press.
REQ-018 SHALL implement FSM states HOLD (no request), PEND_NEXT (advance pending), PEND_LOAD (load pending); pending=1 in both PEND states.
REQ-019 SHALL move HOLD->PEND_NEXT on next-request or auto-request, and HOLD/PEND_NEXT->PEND_LOAD on sel_load, latching sel_value.
REQ-020 SHALL treat further next-requests while in PEND_NEXT as a single advance; a later sel_load in PEND_LOAD SHALL overwrite the latched value.
REQ-021 SHALL, on frame_start in PEND_NEXT, set pattern_sel to (pattern_sel+1) mod NUM_PATTERNS, wrapping NUM_PATTERNS-1 to 0, and return to HOLD.
REQ-022 SHALL, on frame_start in PEND_LOAD, set pattern_sel to the latched value, or to 0 if value >= NUM_PATTERNS, and return to HOLD.
REQ-023 SHALL update pattern_sel and pulse pattern_changed in the cycle after frame_start (one-cycle latency); no update at any other time.
REQ-024 SHALL service a request arriving in the same cycle as frame_start at that frame_start; sel_load has priority over next-request.
REQ-025 SHALL pulse pattern_changed only when the value actually changes; a load of the current value returns to HOLD silently.
REQ-026 SHALL, while auto_en=1, increment frame_cnt on each frame_start in HOLD.
REQ-027 SHALL raise an auto-request when frame_cnt+1 reaches max(hold_frames,1) at frame_start; the switch is taken at that same frame_start.
REQ-028 SHALL clear frame_cnt on every pattern switch and while auto_en=0.

Reset
REQ-029 SHALL, while rst_n=0, force pattern_sel=0, pattern_changed=0, pending=0, frame_cnt=0, FSM=HOLD, and all synchronizer, debounce and edge flops to 0.
REQ-030 SHALL discard any pending request when reset is asserted mid-operation; no switch occurs after reset release without a new request.

Configuration
REQ-031 SHALL compile a debouncer when VGA_PATTERN_SCHED_DEBOUNCE_EN is defined: the synchronized button is accepted only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-032 SHALL, when VGA_PATTERN_SCHED_DEBOUNCE_EN is undefined, edge-detect the synchronized button directly, and contain no debounce counter.

Verification
REQ-033 SHALL check: reset, then one btn_next press mid-frame -> pending=1; pattern_sel 0->1 with pattern_changed one cycle after the next frame_start.
REQ-034 SHALL check: pattern_sel=3, NUM_PATTERNS=4, press -> wraps to 0 at frame_start; three presses within one frame -> single advance.
REQ-035 SHALL check: auto_en=1, hold_frames=3 -> switch every 3rd frame_start; hold_frames=0 -> switch every frame_start.
REQ-036 SHALL check: sel_load with sel_value=2 coincident with frame_start, and a pending next -> pattern_sel=2; sel_value=3 with NUM_PATTERNS=3 -> pattern_sel=0.
REQ-037 SHALL check with the macro defined and DEBOUNCE_CYCLES=8: 5-cycle glitch -> no request; 20-cycle press -> exactly one request.
REQ-038 SHALL check: rst_n low while pending=1 -> all outputs 0; after release, frame_start -> no pattern_changed.

Source files
------------

// File: rtl/vga_pattern_sched.sv
// -----------------------------------------------------------------------------
// vga_pattern_sched
//
// Chooses which test pattern the VGA pattern datapath shows. A change can be
// requested three ways:
//   - a "next" button press,
//   - automatic cycling every hold_frames frames,
//   - a direct load of an index.
// The request is held in a small FSM (HOLD / PEND_NEXT / PEND_LOAD). It is
// applied only at frame_start (the start of vertical blanking), so a pattern
// never changes partway through a visible frame.
//
// Optional feature:
//   VGA_PATTERN_SCHED_DEBOUNCE_EN
//     When defined, the synchronized button is accepted only after
//     DEBOUNCE_CYCLES consecutive equal samples. When undefined, the
//     synchronized button is edge-detected directly.
//
// Parameters:
//   NUM_PATTERNS     number of selectable patterns (2..16)
//   SEL_W            width of the pattern index (2**SEL_W >= NUM_PATTERNS)
//   DEBOUNCE_CYCLES  stable-sample count for button acceptance (>= 2)
//
// Ports:
//   clk              single clock; all state updates on its rising edge
//   rst_n            asynchronous, active-low reset
//   frame_start      one-cycle pulse at the start of vertical blanking
//   btn_next         raw asynchronous "next pattern" button, active-high
//   auto_en          level; enables automatic pattern cycling
//   hold_frames      frames per pattern in auto mode (0 is treated as 1)
//   sel_load         one-cycle pulse requesting a direct pattern load
//   sel_value        index to load, sampled while sel_load is high
//   pattern_sel      registered pattern index
//   pattern_changed  one-cycle pulse with each new pattern_sel value
//   pending          a switch request is waiting for frame_start
//   frame_cnt        frames elapsed on the current pattern in auto mode
// -----------------------------------------------------------------------------
module vga_pattern_sched #(
    parameter int NUM_PATTERNS    = 4,
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             btn_next,
    input  logic             auto_en,
    input  logic [5:0]       hold_frames,
    input  logic             sel_load,
    input  logic [SEL_W-1:0] sel_value,
    output logic [SEL_W-1:0] pattern_sel,
    output logic             pattern_changed,
    output logic             pending,
    output logic [5:0]       frame_cnt
);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        PEND_NEXT = 2'd1,
        PEND_LOAD = 2'd2
    } state_e;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PATTERNS - 1);

    if (NUM_PATTERNS < 2 || NUM_PATTERNS > 16 || (1 << SEL_W) < NUM_PATTERNS ||
        DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("vga_pattern_sched: illegal parameter combination");
    end

    // Button conditioning: 2-flop synchronizer, optional debounce, edge detect.
    logic btn_meta_q;
    logic btn_sync_q;
    logic btn_cond;
    logic btn_prev_q;
    logic next_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_next;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef VGA_PATTERN_SCHED_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            btn_db_q;
    logic            btn_db_d;

    // The counter tracks how many consecutive samples have disagreed with the
    // accepted level. Any agreeing sample restarts the count.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_sync_q != btn_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn_cond = btn_db_q;
`else
    assign btn_cond = btn_sync_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_cond;
        end
    end

    assign next_req = btn_cond & ~btn_prev_q;

    // Request FSM and pattern register.
    state_e           state_q;
    state_e           state_d;
    logic [SEL_W-1:0] load_val_q;
    logic [SEL_W-1:0] load_val_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             changed_q;
    logic             changed_d;
    logic [5:0]       frame_cnt_q;
    logic [5:0]       frame_cnt_d;

    logic             auto_req;
    logic             serviced;
    logic [SEL_W-1:0] target_sel;
    logic [6:0]       cnt_plus1;
    logic [6:0]       hold_eff;

    // Compare in 7 bits so frame_cnt + 1 cannot wrap. A hold of 0 behaves as 1.
    assign cnt_plus1 = {1'b0, frame_cnt_q} + 7'd1;
    assign hold_eff  = (hold_frames == 6'd0) ? 7'd1 : {1'b0, hold_frames};

    always_comb begin
        state_d     = state_q;
        load_val_d  = load_val_q;
        sel_d       = sel_q;
        changed_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        serviced    = 1'b0;
        target_sel  = sel_q;
        auto_req    = frame_start && auto_en && (state_q == HOLD) && (cnt_plus1 >= hold_eff);

        // First fold this cycle's requests into the pending state.
        // A load always wins. Repeated next-requests collapse into one advance.
        case (state_q)
            HOLD: begin
                if (sel_load) begin
                    state_d    = PEND_LOAD;
                    load_val_d = sel_value;
                end else if (next_req || auto_req) begin
                    state_d = PEND_NEXT;
                end
            end
            PEND_NEXT: begin
                if (sel_load) begin
                    state_d    = PEND_LOAD;
                    load_val_d = sel_value;
                end
            end
            PEND_LOAD: begin
                if (sel_load) begin
                    load_val_d = sel_value;
                end
            end
            default: state_d = HOLD;
        endcase

        // Then service the folded request at frame_start. This lets a request
        // that arrives together with frame_start take effect at that frame.
        if (frame_start) begin
            if (state_d == PEND_LOAD) begin
                serviced   = 1'b1;
                target_sel = (32'(load_val_d) < 32'(NUM_PATTERNS)) ? load_val_d : '0;
            end else if (state_d == PEND_NEXT) begin
                serviced   = 1'b1;
                target_sel = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
            end
        end

        if (serviced) begin
            sel_d       = target_sel;
            changed_d   = (target_sel != sel_q);
            state_d     = HOLD;
            frame_cnt_d = '0;
        end else if (frame_start && auto_en) begin
            frame_cnt_d = frame_cnt_q + 6'd1;
        end

        if (!auto_en) begin
            frame_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            load_val_q  <= '0;
            sel_q       <= '0;
            changed_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            load_val_q  <= load_val_d;
            sel_q       <= sel_d;
            changed_q   <= changed_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pattern_sel     = sel_q;
    assign pattern_changed = changed_q;
    assign pending         = (state_q != HOLD);
    assign frame_cnt       = frame_cnt_q;

endmodule
